// File: rtl/fp_pkg.sv
// Shared constants and helpers for the FPU result-packing path.
// Bit patterns are built at 64 bits; callers size-cast to 1+EXP_W+MAN_W.
package fp_pkg;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3;
    localparam logic [2:0] RMM = 3'd4;

    localparam int FLG_NV = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    function automatic logic [63:0] fp_qnan(input int ew, input int mw);
        logic [63:0] v;
        v = ((64'd1 << ew) - 64'd1) << mw;
        v = v | (64'd1 << (mw - 1));
        return v;
    endfunction

    function automatic logic [63:0] fp_inf(input logic sign, input int ew, input int mw);
        logic [63:0] v;
        v = ((64'd1 << ew) - 64'd1) << mw;
        v = v | ({63'd0, sign} << (ew + mw));
        return v;
    endfunction

    function automatic logic [63:0] fp_max_finite(input logic sign, input int ew, input int mw);
        logic [63:0] v;
        v = ((64'd1 << ew) - 64'd2) << mw;
        v = v | ((64'd1 << mw) - 64'd1);
        v = v | ({63'd0, sign} << (ew + mw));
        return v;
    endfunction

    // Unknown mode codes fall through to round-to-nearest-even.
    function automatic logic fp_round_inc(input logic [2:0] mode, input logic sign,
                                          input logic g, input logic r, input logic s,
                                          input logic l);
        logic inc;
        case (mode)
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (g | r | s);
            RUP:     inc = ~sign & (g | r | s);
            RMM:     inc = g;
            default: inc = g & (r | s | l);
        endcase
        return inc;
    endfunction

    function automatic logic fp_ovf_to_inf(input logic [2:0] mode, input logic sign);
        logic to_inf;
        case (mode)
            RTZ:     to_inf = 1'b0;
            RDN:     to_inf = sign;
            RUP:     to_inf = ~sign;
            default: to_inf = 1'b1;
        endcase
        return to_inf;
    endfunction

endpackage

// File: rtl/fp_denorm_shift.sv
// Denormalisation for tiny results: right shift by 1-exp, capped, with
// every shifted-out bit folded into the sticky position.
module fp_denorm_shift
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic signed [EXP_W+1:0] i_exp,
    input  logic        [MAN_W+3:0] i_man,
    output logic        [MAN_W+3:0] o_man,
    output logic        [EXP_W+1:0] o_exp,
    output logic                    o_tiny
);

    localparam int MW   = MAN_W + 4;
    localparam int SH_W = $clog2(MW);

    localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
    localparam logic        [EXP_W+2:0] AMT_ONE  = (EXP_W+3)'(1);
    localparam logic        [EXP_W+2:0] AMT_CAP  = (EXP_W+3)'(MAN_W + 3);

    logic [EXP_W+2:0] w_amt_full;
    logic [SH_W-1:0]  w_amt;
    logic [MW-1:0]    w_shifted;
    logic             w_lost;

    assign o_tiny     = (i_exp <= EXP_ZERO);
    // Sign-extended subtraction; only meaningful (and always positive) when tiny.
    assign w_amt_full = AMT_ONE - {i_exp[EXP_W+1], i_exp};
    assign w_amt      = (w_amt_full > AMT_CAP) ? AMT_CAP[SH_W-1:0] : w_amt_full[SH_W-1:0];
    assign w_shifted  = i_man >> w_amt;
    assign w_lost     = |(i_man & ~({MW{1'b1}} << w_amt));

    always_comb begin
        o_man = i_man;
        o_exp = $unsigned(i_exp);
        if (o_tiny) begin
            o_man = {w_shifted[MW-1:1], w_shifted[0] | w_lost};
            o_exp = '0;
        end
    end

endmodule

// File: rtl/fp_result_packer.sv
// Two-stage result packer: stage 1 denormalises, stage 2 rounds, saturates,
// applies special cases and holds the packed IEEE-754 result for downstream.
module fp_result_packer
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_rnd_mode,
    input  logic                     in_sign,
    input  logic signed [EXP_W+1:0]  in_exp,
    input  logic [MAN_W+3:0]         in_man,
    input  logic                     in_invalid,
    input  logic                     in_inf,
    input  logic                     in_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [3:0]               out_flags
);

    localparam int RES_W = 1 + EXP_W + MAN_W;

    localparam logic [EXP_W+1:0] EXP_ONE = (EXP_W+2)'(1);
    localparam logic [EXP_W+1:0] EXP_SAT = {2'b00, {EXP_W{1'b1}}};

    logic             r_s1_valid;
    logic [2:0]       r_s1_mode;
    logic             r_s1_sign;
    logic             r_s1_invalid;
    logic             r_s1_inf;
    logic             r_s1_zero;
    logic             r_s1_tiny;
    logic [EXP_W+1:0] r_s1_exp;
    logic [MAN_W+3:0] r_s1_man;

    logic             r_s2_valid;
    logic [RES_W-1:0] r_s2_result;
    logic [3:0]       r_s2_flags;

    logic             w_s2_load;
    logic             w_in_fire;
    logic [MAN_W+3:0] w_dn_man;
    logic [EXP_W+1:0] w_dn_exp;
    logic             w_dn_tiny;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign in_ready  = !rst && (!r_s1_valid || w_s2_load);
    assign w_in_fire = in_valid && in_ready;

    fp_denorm_shift #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_denorm (
        .i_exp  (in_exp),
        .i_man  (in_man),
        .o_man  (w_dn_man),
        .o_exp  (w_dn_exp),
        .o_tiny (w_dn_tiny)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_mode    <= RNE;
            r_s1_sign    <= 1'b0;
            r_s1_invalid <= 1'b0;
            r_s1_inf     <= 1'b0;
            r_s1_zero    <= 1'b0;
            r_s1_tiny    <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_man     <= '0;
        end else if (w_in_fire) begin
            r_s1_valid   <= 1'b1;
            r_s1_mode    <= in_rnd_mode;
            r_s1_sign    <= in_sign;
            r_s1_invalid <= in_invalid;
            r_s1_inf     <= in_inf;
            r_s1_zero    <= in_zero;
            r_s1_tiny    <= w_dn_tiny;
            r_s1_exp     <= w_dn_exp;
            r_s1_man     <= w_dn_man;
        end else if (w_s2_load) begin
            r_s1_valid   <= 1'b0;
        end
    end

    // Stage 2 combinational: round, detect overflow, resolve specials.
    logic             w_hidden;
    logic [MAN_W-1:0] w_frac;
    logic             w_g;
    logic             w_r;
    logic             w_s;
    logic             w_inc;
    logic             w_nx;
    logic [MAN_W+1:0] w_sum;
    logic [EXP_W+1:0] w_exp_rnd;
    logic [MAN_W-1:0] w_frac_rnd;
    logic             w_ovf;
    logic [RES_W-1:0] w_res;
    logic [3:0]       w_flg;

    assign w_hidden = r_s1_man[MAN_W+3];
    assign w_frac   = r_s1_man[MAN_W+2:3];
    assign w_g      = r_s1_man[2];
    assign w_r      = r_s1_man[1];
    assign w_s      = r_s1_man[0];
    assign w_nx     = w_g | w_r | w_s;
    assign w_inc    = fp_round_inc(r_s1_mode, r_s1_sign, w_g, w_r, w_s, w_frac[0]);
    assign w_sum    = {1'b0, w_hidden, w_frac} + {{(MAN_W+1){1'b0}}, w_inc};

    always_comb begin
        w_exp_rnd  = r_s1_exp;
        w_frac_rnd = w_sum[MAN_W-1:0];
        if (w_sum[MAN_W+1]) begin
            w_exp_rnd  = r_s1_exp + EXP_ONE;
            w_frac_rnd = '0;
        end else if (r_s1_exp == '0 && w_sum[MAN_W]) begin
            // subnormal rounded up into the smallest normal
            w_exp_rnd = EXP_ONE;
        end
    end

    assign w_ovf = (w_exp_rnd >= EXP_SAT);

    always_comb begin
        w_res         = {r_s1_sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd};
        w_flg         = '0;
        w_flg[FLG_NX] = w_nx;
        w_flg[FLG_UF] = r_s1_tiny && w_nx;
        if (w_ovf) begin
            w_flg[FLG_OF] = 1'b1;
            w_flg[FLG_NX] = 1'b1;
            if (fp_ovf_to_inf(r_s1_mode, r_s1_sign)) begin
                w_res = RES_W'(fp_inf(r_s1_sign, EXP_W, MAN_W));
            end else begin
                w_res = RES_W'(fp_max_finite(r_s1_sign, EXP_W, MAN_W));
            end
        end
        if (r_s1_invalid) begin
            w_res         = RES_W'(fp_qnan(EXP_W, MAN_W));
            w_flg         = '0;
            w_flg[FLG_NV] = 1'b1;
        end else if (r_s1_inf) begin
            w_res = RES_W'(fp_inf(r_s1_sign, EXP_W, MAN_W));
            w_flg = '0;
        end else if (r_s1_zero) begin
            w_res = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
            w_flg = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_flags  <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result <= w_res;
                r_s2_flags  <= w_flg;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_s2_result;
    assign out_flags  = r_s2_flags;

endmodule

// File: tb/tb_fp_result_packer.sv
// Directed bench for fp_result_packer with hand-computed binary32 results.
module tb_fp_result_packer;
    import fp_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_rnd_mode;
    logic              in_sign;
    logic signed [9:0] in_exp;
    logic [26:0]       in_man;
    logic              in_invalid;
    logic              in_inf;
    logic              in_zero;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [3:0]        out_flags;

    int total;
    int bad;

    fp_result_packer #(.EXP_W(8), .MAN_W(23)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rnd_mode (in_rnd_mode),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_man      (in_man),
        .in_invalid  (in_invalid),
        .in_inf      (in_inf),
        .in_zero     (in_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [26:0] mk_man(input logic h, input logic [22:0] f, input logic [2:0] grs);
        return {h, f, grs};
    endfunction

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Sends one beat with out_ready high and returns the first output beat seen.
    task automatic run_beat(input logic [2:0] mode, input logic sgn, input logic signed [9:0] e,
                            input logic [26:0] m, input logic inv, input logic inf, input logic zro,
                            output logic [31:0] res, output logic [3:0] flg, output int lat,
                            output logic to);
        int w;
        to          = 1'b0;
        out_ready   = 1'b1;
        in_rnd_mode = mode;
        in_sign     = sgn;
        in_exp      = e;
        in_man      = m;
        in_invalid  = inv;
        in_inf      = inf;
        in_zero     = zro;
        in_valid    = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) to = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) to = 1'b1;
        res = out_result;
        flg = out_flags;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if (out_result !== 32'h0) begin bad++; $display("FAIL reset_out_result got=%h want=00000000", out_result); end
        total++;
        if (out_flags !== 4'h0) begin bad++; $display("FAIL reset_out_flags got=%b want=0000", out_flags); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_normal;
        logic [31:0] res; logic [3:0] flg; int lat; logic to;
        run_beat(RNE, 1'b0, 10'sd127, mk_man(1'b1, 23'h0, 3'b000), 1'b0, 1'b0, 1'b0, res, flg, lat, to);
        total++;
        if (to) begin bad++; $display("FAIL normal_timeout got=timeout want=beat"); end
        total++;
        if (res !== 32'h3F800000) begin bad++; $display("FAIL normal_res got=%h want=3f800000", res); end
        total++;
        if (flg !== 4'b0000) begin bad++; $display("FAIL normal_flags got=%b want=0000", flg); end
        total++;
        if (lat != 2) begin bad++; $display("FAIL normal_latency got=%0d want=2", lat); end
    endtask

    task automatic test_round_carry;
        logic [31:0] res; logic [3:0] flg; int lat; logic to;
        logic [2:0]  modes [2];
        logic [31:0] want  [2];
        modes = '{RNE, RTZ};
        want  = '{32'h40000000, 32'h3FFFFFFF};
        for (int k = 0; k < 2; k++) begin
            run_beat(modes[k], 1'b0, 10'sd127, mk_man(1'b1, 23'h7FFFFF, 3'b100), 1'b0, 1'b0, 1'b0, res, flg, lat, to);
            total++;
            if (to || res !== want[k]) begin bad++; $display("FAIL carry_res[%0d] got=%h want=%h", k, res, want[k]); end
            total++;
            if (flg !== 4'b0001) begin bad++; $display("FAIL carry_flags[%0d] got=%b want=0001", k, flg); end
        end
    endtask

    task automatic test_overflow;
        logic [31:0] res; logic [3:0] flg; int lat; logic to;
        logic [2:0]  modes [4];
        logic        sgns  [4];
        logic [31:0] want  [4];
        modes = '{RNE, RTZ, RUP, RDN};
        sgns  = '{1'b0, 1'b0, 1'b1, 1'b1};
        want  = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'hFF800000};
        for (int k = 0; k < 4; k++) begin
            run_beat(modes[k], sgns[k], 10'sd255, mk_man(1'b1, 23'h0, 3'b000), 1'b0, 1'b0, 1'b0, res, flg, lat, to);
            total++;
            if (to || res !== want[k]) begin bad++; $display("FAIL ovf_res[%0d] got=%h want=%h", k, res, want[k]); end
            total++;
            if (flg !== 4'b0101) begin bad++; $display("FAIL ovf_flags[%0d] got=%b want=0101", k, flg); end
        end
    endtask

    task automatic test_subnormal;
        logic [31:0] res; logic [3:0] flg; int lat; logic to;
        logic [22:0] fr   [3];
        logic [2:0]  md   [3];
        logic [31:0] want [3];
        logic [3:0]  wflg [3];
        fr   = '{23'h000000, 23'h000001, 23'h7FFFFF};
        md   = '{RNE, RNE, RUP};
        want = '{32'h00200000, 32'h00200000, 32'h00800000};
        wflg = '{4'b0000, 4'b0011, 4'b0011};
        for (int k = 0; k < 3; k++) begin
            // k=2: 0x1.FFFFFE * 2^-126 shifted once, RUP carries into the smallest normal
            run_beat(md[k], 1'b0, (k == 2) ? 10'sd0 : -10'sd1, mk_man(1'b1, fr[k], 3'b000),
                     1'b0, 1'b0, 1'b0, res, flg, lat, to);
            total++;
            if (to || res !== want[k]) begin bad++; $display("FAIL sub_res[%0d] got=%h want=%h", k, res, want[k]); end
            total++;
            if (flg !== wflg[k]) begin bad++; $display("FAIL sub_flags[%0d] got=%b want=%b", k, flg, wflg[k]); end
        end
        // far below range: only sticky survives, RUP gives smallest subnormal
        run_beat(RUP, 1'b0, -10'sd200, mk_man(1'b1, 23'h0, 3'b000), 1'b0, 1'b0, 1'b0, res, flg, lat, to);
        total++;
        if (to || res !== 32'h00000001) begin bad++; $display("FAIL sub_deep_res got=%h want=00000001", res); end
        total++;
        if (flg !== 4'b0011) begin bad++; $display("FAIL sub_deep_flags got=%b want=0011", flg); end
    endtask

    task automatic test_specials;
        logic [31:0] res; logic [3:0] flg; int lat; logic to;
        run_beat(RNE, 1'b1, 10'sd255, mk_man(1'b1, 23'h0, 3'b111), 1'b1, 1'b0, 1'b1, res, flg, lat, to);
        total++;
        if (to || res !== 32'h7FC00000) begin bad++; $display("FAIL nan_res got=%h want=7fc00000", res); end
        total++;
        if (flg !== 4'b1000) begin bad++; $display("FAIL nan_flags got=%b want=1000", flg); end
        run_beat(RNE, 1'b1, 10'sd100, mk_man(1'b1, 23'h0, 3'b111), 1'b0, 1'b1, 1'b0, res, flg, lat, to);
        total++;
        if (to || res !== 32'hFF800000) begin bad++; $display("FAIL inf_res got=%h want=ff800000", res); end
        total++;
        if (flg !== 4'b0000) begin bad++; $display("FAIL inf_flags got=%b want=0000", flg); end
        run_beat(RTZ, 1'b1, 10'sd100, mk_man(1'b0, 23'h0, 3'b000), 1'b0, 1'b0, 1'b1, res, flg, lat, to);
        total++;
        if (to || res !== 32'h80000000) begin bad++; $display("FAIL zero_res got=%h want=80000000", res); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] want [4];
        int sent; int recv; logic fire_in;
        want = '{32'h3F800000, 32'h40000001, 32'h40800002, 32'h41000003};
        idle(3);
        sent = 0;
        recv = 0;
        in_rnd_mode = RNE; in_sign = 1'b0; in_invalid = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
        for (int c = 0; c < 40 && recv < 4; c++) begin
            out_ready = (c >= 3);
            if (sent < 4) begin
                in_valid = 1'b1;
                in_exp   = 10'(127 + sent);
                in_man   = mk_man(1'b1, 23'(sent), 3'b000);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 2) begin
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready_full got=%b want=0", in_ready); end
                total++;
                if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_out_valid_stall got=%b want=1", out_valid); end
            end
            fire_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                total++;
                if (recv >= 4 || out_result !== want[recv]) begin
                    bad++; $display("FAIL b2b_order[%0d] got=%h want=%h", recv, out_result, want[recv % 4]);
                end
                recv++;
            end
            @(posedge clk); #1;
            if (fire_in) sent++;
        end
        in_valid = 1'b0;
        total++;
        if (recv != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", recv); end
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_duplicate got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid_stall;
        logic [31:0] res; logic [3:0] flg; int lat; logic to;
        int stale;
        idle(3);
        out_ready = 1'b0;
        in_rnd_mode = RNE; in_sign = 1'b0; in_invalid = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
        in_exp = 10'sd130;
        in_man = mk_man(1'b1, 23'h123, 3'b000);
        in_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_stall_out_valid got=%b want=0", out_valid); end
        total++;
        if (out_result !== 32'h0) begin bad++; $display("FAIL rst_stall_out_result got=%h want=00000000", out_result); end
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        total++;
        if (stale != 0) begin bad++; $display("FAIL rst_stale_beats got=%0d want=0", stale); end
        run_beat(RNE, 1'b0, 10'sd127, mk_man(1'b1, 23'h0, 3'b000), 1'b0, 1'b0, 1'b0, res, flg, lat, to);
        total++;
        if (to || res !== 32'h3F800000) begin bad++; $display("FAIL rst_recover_res got=%h want=3f800000", res); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_rnd_mode = RNE; in_sign = 1'b0; in_exp = '0; in_man = '0;
        in_invalid = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
        @(posedge clk); #1;
        test_reset;
        test_normal;
        test_round_carry;
        test_overflow;
        test_subnormal;
        test_specials;
        test_back_to_back;
        test_reset_mid_stall;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
